can_crc15_engine: RTL and testbench

- Parametrised CAN CRC-15 engine (polynomial 0x4599, init 0, MSB-first).
- Computes the CRC over a frame of programmable bit length. Data arrives as a valid/ready stream of DATA_W-bit beats.
- Handles a partial final beat and reports the result with a one-cycle done strobe.
- Sits between the CAN frame serialiser/deserialiser and the bit-stuffing stage; it is the generalised successor of the fixed 8-bit CRC path.

---
 rtl/can_pkg.sv | 23 ++
 rtl/can_crc15_step.sv | 24 ++
 rtl/can_crc15_engine.sv | 113 +++++++++++
 tb/tb_can_crc15_engine.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 constants, CRC type, engine state encoding
// and the single-bit CRC-15 update used by the step logic.
package can_pkg;

  typedef logic [14:0] crc15_t;

  localparam crc15_t CAN_CRC15_POLY = 15'h4599;
  localparam crc15_t CAN_CRC15_INIT = 15'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One MSB-first LFSR step of the CAN CRC-15.
  function automatic crc15_t crc15_bit(input crc15_t crc, input logic data_bit);
    logic fb;
    fb = data_bit ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : CAN_CRC15_INIT);
  endfunction

endpackage

// File: rtl/can_crc15_step.sv
// Combinational CRC-15 update over one beat: applies the first nbits bits of
// data (MSB first) to crc_in; the remaining low-order bits are bypassed.
module can_crc15_step
  import can_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int NB_W   = $clog2(DATA_W + 1)
) (
  input  crc15_t            crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [NB_W-1:0]   nbits,
  output crc15_t            crc_out
);

  always_comb begin
    crc15_t crc;
    crc = crc_in;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(nbits)) crc = crc15_bit(crc, data[DATA_W-1-i]);
    end
    crc_out = crc;
  end

endmodule

// File: rtl/can_crc15_engine.sv
// CAN CRC-15 engine over a programmable-length frame fed as DATA_W-bit beats.
// Define CAN_CRC_CHECK_EN to add the receive-side crc_rx compare and crc_ok.
module can_crc15_engine
  import can_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              crc_valid,
  output logic [14:0]       crc_out
`ifdef CAN_CRC_CHECK_EN
  ,
  input  logic [14:0]       crc_rx,
  output logic              crc_ok
`endif
);

  localparam int NB_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  crc15_t            crc_q, crc_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              crc_valid_q, crc_valid_d;
  logic [NB_W-1:0]   nbits;
  crc15_t            step_crc;
  logic              beat;

  can_crc15_step #(.DATA_W(DATA_W)) u_step (
    .crc_in  (crc_q),
    .data    (in_data),
    .nbits   (nbits),
    .crc_out (step_crc)
  );

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    nbits       = (32'(remaining_q) >= DATA_W) ? NB_W'(DATA_W) : NB_W'(remaining_q);
    beat        = in_valid && in_ready_q;
    state_d     = state_q;
    remaining_d = remaining_q;
    crc_d       = crc_q;
    case (state_q)
      IDLE: if (start) begin
        crc_d       = CAN_CRC15_INIT;
        remaining_d = frame_len;
        state_d     = (frame_len == '0) ? DONE : RUN;
      end
      RUN: if (beat) begin
        crc_d       = step_crc;
        remaining_d = remaining_q - LEN_W'(nbits);
        if (remaining_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they align with it.
    in_ready_d  = (state_d == RUN);
    busy_d      = (state_d != IDLE);
    crc_valid_d = (state_d == DONE);
  end

`ifdef CAN_CRC_CHECK_EN
  logic crc_ok_q, crc_ok_d;

  always_comb begin
    crc_ok_d = crc_ok_q;
    if (state_q == IDLE && start) crc_ok_d = 1'b0;
    else if (state_q == DONE)     crc_ok_d = (crc_rx == crc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_ok_q <= 1'b0;
    else     crc_ok_q <= crc_ok_d;
  end

  assign crc_ok = crc_ok_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      crc_q       <= CAN_CRC15_INIT;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      crc_q       <= crc_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_q;

endmodule

// File: tb/tb_can_crc15_engine.sv
// Self-checking bench for can_crc15_engine (DATA_W=8, LEN_W=7) against a
// polynomial long-division CRC-15 model; covers crc_ok when CAN_CRC_CHECK_EN is set.
module tb_can_crc15_engine;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 7;

  typedef bit bitq_t[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              crc_valid;
  logic [14:0]       crc_out;
`ifdef CAN_CRC_CHECK_EN
  logic [14:0]       crc_rx;
  logic              crc_ok;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] frame_bytes[16];

  can_crc15_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .crc_valid (crc_valid),
    .crc_out   (crc_out)
`ifdef CAN_CRC_CHECK_EN
    ,
    .crc_rx    (crc_rx),
    .crc_ok    (crc_ok)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] observed, input logic [31:0] expected, input string tag);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Frame bits in wire order: byte 0 MSB first.
  function automatic bitq_t make_bits(input int len);
    bitq_t q;
    for (int k = 0; k < len; k++) q.push_back(frame_bytes[k/8][7 - (k % 8)]);
    return q;
  endfunction

  // CRC = M(x) * x^15 mod G(x), G = x^15 + 0x4599, by plain long division.
  function automatic logic [14:0] ref_crc(input bitq_t msg);
    bitq_t       m;
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    m = msg;
    for (int j = 0; j < 15; j++) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int j = 0; j < 15; j++) r[14-j] = m[msg.size()+j];
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check(in_ready,  0, {tag, "_in_ready"});
    check(busy,      0, {tag, "_busy"});
    check(crc_valid, 0, {tag, "_crc_valid"});
    check(crc_out,   0, {tag, "_crc_out"});
`ifdef CAN_CRC_CHECK_EN
    check(crc_ok,    0, {tag, "_crc_ok"});
`endif
  endtask

  // Entered and left at #1 after a rising edge with the engine in IDLE.
  task automatic run_frame(input int len, input bit gaps, input bit poke_start,
                           input bit rx_bad, input string tag);
    logic [14:0] exp_crc;
    int          nbeats;
    int          b;
    int          cyc;
    logic        rdy;
    exp_crc = ref_crc(make_bits(len));
    nbeats  = (len + 7) / 8;
`ifdef CAN_CRC_CHECK_EN
    crc_rx = rx_bad ? (exp_crc ^ 15'h0001) : exp_crc;
`endif
    check(in_ready, 0, {tag, "_idle_ready"});
    start     = 1'b1;
    frame_len = LEN_W'(len);
    @(posedge clk); #1;
    start     = poke_start;
    frame_len = '0;
    check(busy, 1, {tag, "_busy_after_start"});
    if (len != 0) begin
      b   = 0;
      cyc = 0;
      while (b < nbeats && cyc < 200) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = frame_bytes[b];
        rdy      = in_ready;
        check(rdy,       1, {tag, "_ready_in_run"});
        check(crc_valid, 0, {tag, "_no_early_valid"});
        @(posedge clk); #1;
        if (in_valid && rdy) b++;
        cyc++;
      end
      in_valid = 1'b0;
      check(b >= nbeats, 1, {tag, "_beat_timeout"});
    end
    check(crc_valid, 1,       {tag, "_crc_valid"});
    check(crc_out,   exp_crc, {tag, "_crc_out"});
    check(in_ready,  0,       {tag, "_ready_in_done"});
    check(busy,      1,       {tag, "_busy_in_done"});
    @(posedge clk); #1;
    start = 1'b0;
    check(crc_valid, 0,       {tag, "_valid_one_cycle"});
    check(busy,      0,       {tag, "_busy_idle"});
    check(in_ready,  0,       {tag, "_ready_idle"});
    check(crc_out,   exp_crc, {tag, "_crc_hold"});
`ifdef CAN_CRC_CHECK_EN
    check(crc_ok, !rx_bad, {tag, "_crc_ok"});
`endif
  endtask

  task automatic load_check_string();
    for (int i = 0; i < 16; i++) frame_bytes[i] = (i < 9) ? 8'(8'h31 + i) : 8'h00;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b0;
    in_data   = '0;
`ifdef CAN_CRC_CHECK_EN
    crc_rx    = '0;
`endif
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // CRC-15/CAN check string "123456789".
    load_check_string();
    run_frame(72, 0, 0, 0, "check_value");
    check(crc_out, 15'h059E, "check_value_const");

    // Random stalls, start held high through RUN/DONE, mismatching crc_rx.
    run_frame(72, 1, 1, 1, "gaps_poke");
    check(crc_out, 15'h059E, "gaps_const");

    frame_bytes[0] = 8'h80;
    run_frame(1, 0, 0, 0, "len1_msb");
    check(crc_out, 15'h4599, "len1_msb_const");
    frame_bytes[0] = 8'h7F;
    run_frame(1, 0, 0, 0, "len1_low_ignored");
    check(crc_out, 15'h0000, "len1_low_const");

    run_frame(0, 0, 1, 0, "zero_len");

    // Abort mid-frame with an asynchronous reset.
    load_check_string();
    start     = 1'b1;
    frame_len = LEN_W'(72);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = frame_bytes[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check(crc_out, ref_crc(make_bits(32)), "partial_crc");
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(72, 0, 0, 0, "after_abort");
    check(crc_out, 15'h059E, "after_abort_const");

    for (int t = 0; t < 20; t++) begin
      int len;
      len = int'($urandom_range(1, 127));
      for (int i = 0; i < 16; i++) frame_bytes[i] = 8'($urandom);
      run_frame(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rand%0d_len%0d", t, len));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
